// File: rtl/spi_master_gen.sv
// SPI master with configurable word width, SCK divider, one-hot active-low slave selects,
// all four CPOL/CPHA modes and MSB/LSB-first ordering. Configuration is latched on start.
module spi_master_gen #(
   parameter int DATA_W = 8,
   parameter int NUM_SS = 1,
   parameter int SEL_W  = 3,
   parameter int DIV_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsb_first,
   input  logic [SEL_W-1:0]  ss_sel,
   input  logic [DIV_W-1:0]  clk_div,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_data,
   output logic              sck,
   output logic              mosi,
   output logic              mosi_oe,
   input  logic              miso,
   output logic [NUM_SS-1:0] ss_n
);

   localparam int BC_W = $clog2(2*DATA_W) + 1;
   localparam logic [BC_W-1:0] LAST_EDGE = BC_W'(2*DATA_W - 1);

   typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

   state_t            state, state_nxt;
   logic [DIV_W-1:0]  div_cnt;
   logic [BC_W-1:0]   bit_cnt;
   logic [DIV_W-1:0]  clk_div_q;
   logic              cpha_q;
   logic              lsb_q;
   logic [DATA_W-1:0] tx_sr;
   logic [DATA_W-1:0] rx_sr;
   logic [NUM_SS-1:0] ss_dec;

   logic period_end, edge_now, leading, last_edge, do_sample, do_shift;

   // bit_cnt holds the number of SCK edges already produced; even count means next edge is leading
   assign period_end = (div_cnt == clk_div_q);
   assign edge_now   = (state == XFER) && period_end;
   assign leading    = ~bit_cnt[0];
   assign last_edge  = (bit_cnt == LAST_EDGE);
   assign do_sample  = edge_now && (leading ^ cpha_q);
   assign do_shift   = edge_now && (cpha_q ? (leading && (bit_cnt != '0))
                                           : (!leading && !last_edge));

   assign busy    = (state != IDLE);
   assign mosi_oe = busy;

   always_comb begin
      ss_dec = '1;
      for (int i = 0; i < NUM_SS; i++) begin
         if (int'(ss_sel) == i) ss_dec[i] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = SETUP;
         SETUP:   if (period_end) state_nxt = XFER;
         XFER:    if (period_end && last_edge) state_nxt = HOLD;
         HOLD:    if (period_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt   <= '0;
         bit_cnt   <= '0;
         clk_div_q <= '0;
         cpha_q    <= 1'b0;
         lsb_q     <= 1'b0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         rx_data   <= '0;
         done      <= 1'b0;
         sck       <= 1'b0;
         mosi      <= 1'b0;
         ss_n      <= '1;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            div_cnt <= '0;
            sck     <= cpol;
            if (start) begin
               clk_div_q <= clk_div;
               cpha_q    <= cpha;
               lsb_q     <= lsb_first;
               tx_sr     <= tx_data;
               rx_sr     <= '0;
               bit_cnt   <= '0;
               mosi      <= lsb_first ? tx_data[0] : tx_data[DATA_W-1];
               ss_n      <= ss_dec;
            end
         end else begin
            div_cnt <= period_end ? '0 : div_cnt + DIV_W'(1);
            if (edge_now) begin
               sck     <= ~sck;
               bit_cnt <= bit_cnt + BC_W'(1);
            end
            if (do_sample) begin
               rx_sr <= lsb_q ? {miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso};
            end
            // tx_sr keeps the bit currently on mosi in its outgoing position
            if (do_shift) begin
               if (lsb_q) begin
                  mosi  <= tx_sr[1];
                  tx_sr <= {1'b0, tx_sr[DATA_W-1:1]};
               end else begin
                  mosi  <= tx_sr[DATA_W-2];
                  tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
               end
            end
            if ((state == HOLD) && period_end) begin
               done    <= 1'b1;
               rx_data <= rx_sr;
               mosi    <= 1'b0;
               ss_n    <= '1;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_master_gen.sv
// Bench for spi_master_gen: an 8-bit/4-slave instance for mode, ordering, select and reset
// scenarios, and a 16-bit instance for back-to-back transfers.
module tb_spi_master_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic       start_a = 0, cpol_a = 0, cpha_a = 0, lsb_a = 0, loop_a = 0, miso_drv_a = 0;
   logic [7:0] tx_a = 0, div_a = 0;
   logic [2:0] sel_a = 0;
   logic       busy_a, done_a, sck_a, mosi_a, oe_a, miso_a;
   logic [7:0] rx_a;
   logic [3:0] ssn_a;
   assign miso_a = loop_a ? mosi_a : miso_drv_a;

   logic        start_b = 0, cpol_b = 0, cpha_b = 0, lsb_b = 0;
   logic [15:0] tx_b = 0;
   logic [7:0]  div_b = 0;
   logic [2:0]  sel_b = 0;
   logic        busy_b, done_b, sck_b, mosi_b, oe_b;
   logic [15:0] rx_b;
   logic [0:0]  ssn_b;

   spi_master_gen #(.DATA_W(8), .NUM_SS(4), .SEL_W(3), .DIV_W(8)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .tx_data(tx_a), .cpol(cpol_a), .cpha(cpha_a),
      .lsb_first(lsb_a), .ss_sel(sel_a), .clk_div(div_a), .busy(busy_a), .done(done_a),
      .rx_data(rx_a), .sck(sck_a), .mosi(mosi_a), .mosi_oe(oe_a), .miso(miso_a), .ss_n(ssn_a));

   spi_master_gen #(.DATA_W(16), .NUM_SS(1), .SEL_W(3), .DIV_W(8)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .tx_data(tx_b), .cpol(cpol_b), .cpha(cpha_b),
      .lsb_first(lsb_b), .ss_sel(sel_b), .clk_div(div_b), .busy(busy_b), .done(done_b),
      .rx_data(rx_b), .sck(sck_b), .mosi(mosi_b), .mosi_oe(oe_b), .miso(mosi_b), .ss_n(ssn_b));

   // j-th bit on the wire for a word in the given order
   function automatic bit wire_bit(input logic [7:0] w, input bit lsb, input int j);
      return lsb ? w[j] : w[7-j];
   endfunction

   task automatic test_reset();
      @(negedge clk);
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
      checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_a); end
      checks++; if (rx_a !== 8'h00) begin errors++; $display("FAIL reset_rx got %h want 00", rx_a); end
      checks++; if ({sck_a, mosi_a, oe_a} !== 3'b000) begin errors++; $display("FAIL reset_pins got %b want 000", {sck_a, mosi_a, oe_a}); end
      checks++; if (ssn_a !== 4'hF) begin errors++; $display("FAIL reset_ssn got %b want 1111", ssn_a); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // One transfer on instance A, watching every SCK edge against the wire-level rules.
   task automatic run_a(input logic [7:0] tx, input logic [7:0] src, input bit cp, input bit ch,
                        input bit lsb, input bit loop, input logic [2:0] sel, input logic [7:0] div,
                        input bit mid_start, input string tag);
      int h, busy_cnt, edge_n, s_idx, cyc, mosi_bad, ss_bad, tim_bad, lvl_bad;
      bit got_done, prev_sck, samp;
      logic [7:0] exp_rx;
      logic [3:0] exp_ss;
      h = int'(div) + 1;
      exp_rx = loop ? tx : src;
      exp_ss = (sel < 3'd4) ? ~(4'b0001 << sel) : 4'hF;
      busy_cnt = 0; edge_n = 0; s_idx = 0; cyc = 0;
      mosi_bad = 0; ss_bad = 0; tim_bad = 0; lvl_bad = 0; got_done = 0;
      @(negedge clk);
      tx_a = tx; cpol_a = cp; cpha_a = ch; lsb_a = lsb; sel_a = sel; div_a = div;
      loop_a = loop; miso_drv_a = wire_bit(src, lsb, 0); start_a = 1'b1;
      prev_sck = cp;
      while (!got_done && cyc < 18*h + 20) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            start_a = 1'b0; tx_a = 8'($urandom); cpol_a = 1'($urandom); cpha_a = 1'($urandom);
            lsb_a = 1'($urandom); sel_a = 3'($urandom); div_a = 8'($urandom_range(0, 7));
         end
         if (mid_start && cyc > 1) begin
            start_a = (cyc == 6);
            if (cyc == 6) tx_a = 8'h00;
         end
         if (done_a) begin
            got_done = 1;
            checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL %s done_busy got %b want 0", tag, busy_a); end
            checks++; if (ssn_a !== 4'hF) begin errors++; $display("FAIL %s done_ssn got %b want 1111", tag, ssn_a); end
            checks++; if (rx_a !== exp_rx) begin errors++; $display("FAIL %s rx_data got %h want %h", tag, rx_a, exp_rx); end
         end else if (busy_a) begin
            busy_cnt++;
            if (ssn_a !== exp_ss) ss_bad++;
            if (sck_a !== prev_sck) begin
               edge_n++;
               if (busy_cnt != (edge_n + 1) * h + 1) tim_bad++;
               if (sck_a !== (((edge_n % 2) == 1) ? !cp : cp)) lvl_bad++;
               samp = ((edge_n % 2) == 1) ^ ch;
               if (samp) begin
                  if (s_idx < 8 && mosi_a !== wire_bit(tx, lsb, s_idx)) mosi_bad++;
                  s_idx++;
                  if (s_idx < 8) miso_drv_a = wire_bit(src, lsb, s_idx);
               end
               prev_sck = sck_a;
            end
         end
      end
      start_a = 1'b0;
      checks++; if (!got_done) begin errors++; $display("FAIL %s done_seen got 0 want 1 within %0d cycles", tag, 18*h + 20); end
      checks++; if (busy_cnt != 18*h) begin errors++; $display("FAIL %s busy_cycles got %0d want %0d", tag, busy_cnt, 18*h); end
      checks++; if (edge_n != 16) begin errors++; $display("FAIL %s sck_edges got %0d want 16", tag, edge_n); end
      checks++; if (s_idx != 8 || mosi_bad != 0) begin errors++; $display("FAIL %s mosi_bits got %0d samples %0d bad want 8 samples 0 bad", tag, s_idx, mosi_bad); end
      checks++; if (ss_bad != 0) begin errors++; $display("FAIL %s ssn_busy got %0d bad cycles want 0 (ss_n %b)", tag, ss_bad, exp_ss); end
      checks++; if (tim_bad != 0 || lvl_bad != 0) begin errors++; $display("FAIL %s sck_shape got %0d timing %0d level bad want 0", tag, tim_bad, lvl_bad); end
      @(negedge clk);
      checks++; if ({done_a, busy_a, mosi_a} !== 3'b000) begin errors++; $display("FAIL %s after_done got done/busy/mosi %b want 000", tag, {done_a, busy_a, mosi_a}); end
      checks++; if (rx_a !== exp_rx) begin errors++; $display("FAIL %s rx_held got %h want %h", tag, rx_a, exp_rx); end
   endtask

   task automatic test_mode0_loop();  run_a(8'hA5, 8'h00, 0, 0, 0, 1, 3'd0, 8'd0, 0, "mode0_loop"); endtask
   task automatic test_mode3_ones();  run_a(8'h3C, 8'hFF, 1, 1, 0, 0, 3'd1, 8'd3, 0, "mode3_ones"); endtask
   task automatic test_lsb_mode1();   run_a(8'h01, 8'h00, 0, 1, 1, 1, 3'd3, 8'd0, 0, "lsb_mode1"); endtask

   task automatic test_ss_decode();
      run_a(8'h5A, 8'hC3, 1, 0, 0, 0, 3'd2, 8'd1, 0, "ss_sel2");
      run_a(8'h96, 8'h2D, 0, 0, 1, 0, 3'd5, 8'd0, 0, "ss_sel5");
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         run_a(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               3'($urandom_range(0, 7)), 8'($urandom_range(0, 3)), 0, $sformatf("rand%0d", i));
      end
   endtask

   task automatic test_start_ignored();
      run_a(8'hA5, 8'h00, 0, 0, 0, 1, 3'd0, 8'd0, 1, "start_busy");
      repeat (3) @(negedge clk);
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL start_busy_no_restart got busy %b want 0", busy_a); end
   endtask

   task automatic test_reset_mid();
      int dones;
      dones = 0;
      @(negedge clk);
      tx_a = 8'hA5; cpol_a = 0; cpha_a = 0; lsb_a = 0; sel_a = 0; div_a = 0; loop_a = 1; start_a = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         start_a = 1'b0;
         if (done_a) dones++;
      end
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_busy got %b want 1", busy_a); end
      rst = 1'b1;
      #1;
      checks++; if ({busy_a, done_a, sck_a, mosi_a, oe_a} !== 5'b0) begin errors++; $display("FAIL rst_mid_pins got %b want 00000", {busy_a, done_a, sck_a, mosi_a, oe_a}); end
      checks++; if (ssn_a !== 4'hF || rx_a !== 8'h00) begin errors++; $display("FAIL rst_mid_ssn_rx got %b/%h want 1111/00", ssn_a, rx_a); end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (done_a || busy_a) dones++;
      end
      checks++; if (dones != 0) begin errors++; $display("FAIL rst_mid_no_done got %0d done/busy cycles want 0", dones); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] words [2];
      int h, wi, cyc, busy_cnt;
      bit chk_next;
      words[0] = 16'h1234; words[1] = 16'hBEEF;
      h = $urandom_range(1, 2);
      wi = 0; cyc = 0; busy_cnt = 0; chk_next = 0;
      @(negedge clk);
      div_b = 8'(h - 1); cpol_b = 1'($urandom); cpha_b = 1'($urandom); lsb_b = 1'($urandom);
      sel_b = 3'd0; tx_b = words[0]; start_b = 1'b1;
      while (wi < 2 && cyc < 68*h + 40) begin
         @(negedge clk);
         cyc++;
         start_b = 1'b0;
         if (done_b) begin
            checks++; if (rx_b !== words[wi]) begin errors++; $display("FAIL b2b_rx%0d got %h want %h", wi, rx_b, words[wi]); end
            checks++; if (busy_cnt != 34*h) begin errors++; $display("FAIL b2b_busy%0d got %0d want %0d", wi, busy_cnt, 34*h); end
            checks++; if (ssn_b !== 1'b1) begin errors++; $display("FAIL b2b_ssn_done%0d got %b want 1", wi, ssn_b); end
            busy_cnt = 0;
            wi++;
            if (wi < 2) begin
               tx_b = words[wi]; start_b = 1'b1; chk_next = 1;
            end
         end else begin
            if (busy_b) busy_cnt++;
            if (chk_next) begin
               checks++; if ({busy_b, ssn_b} !== 2'b10) begin errors++; $display("FAIL b2b_restart got busy/ss_n %b want 10", {busy_b, ssn_b}); end
               chk_next = 0;
            end
         end
      end
      checks++; if (wi != 2) begin errors++; $display("FAIL b2b_words got %0d want 2 within %0d cycles", wi, 68*h + 40); end
   endtask

   initial begin
      test_reset();
      test_mode0_loop();
      test_mode3_ones();
      test_lsb_mode1();
      test_ss_decode();
      test_random();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_master_gen.md
Name: spi_master_gen

Overview:
Parametrised SPI master, the successor of the fixed 8-bit SPI interface. It adds configurable word width, a programmable SCK divider, multiple one-hot-decoded active-low slave selects, all four CPOL/CPHA modes, and MSB/LSB-first ordering. The CPU side uses separate tx/rx buses with a start/busy/done handshake instead of a shared tristate bus. It sits between the CPU register interface and the off-chip SPI pins.

Parameters:
DATA_W, 8, bits per transfer word (2..32)
NUM_SS, 1, number of slave-select lines (1..8)
SEL_W, 3, width of ss_sel (must satisfy 2**SEL_W >= NUM_SS)
DIV_W, 8, width of clock-divider field

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request; accepted only when busy=0
tx_data  input  DATA_W  word to transmit, latched on accepted start
cpol  input  1  SCK idle level, latched on start
cpha  input  1  0: sample on leading edge; 1: sample on trailing edge; latched on start
lsb_first  input  1  1: shift LSB first; latched on start
ss_sel  input  SEL_W  slave index, latched on start; index >= NUM_SS means no slave asserted
clk_div  input  DIV_W  half-period H = clk_div+1 clk cycles, latched on start
busy  output  1  transfer in progress
done  output  1  one-cycle pulse at transfer end
rx_data  output  DATA_W  last received word, held until next done
sck  output  1  SPI clock
mosi  output  1  SPI data out
mosi_oe  output  1  high while busy (for shared-bus tristating at top level)
miso  input  1  SPI data in
ss_n  output  NUM_SS  active-low slave selects

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, done=0, rx_data=0, sck=0, mosi=0, mosi_oe=0, ss_n=all ones, divider counter=0, bit counter=0.
- IDLE: sck tracks the cpol input (registered, 1-cycle lag); ss_n all ones; mosi=0. A start with busy=0 latches all config and tx_data; next cycle: state=SETUP, busy=1.
- SETUP (H cycles): selected ss_n bit low; mosi = first bit (tx[DATA_W-1], or tx[0] if lsb_first); sck at idle level.
- XFER: 2*DATA_W SCK edges, each after H cycles; edge 1 is leading (away from cpol).
  - cpha=0: sample miso on leading edges; shift out the next bit on trailing edges (no shift after the last trailing edge).
  - cpha=1: shift out on leading edges (first leading edge presents bit 0 of the sequence); sample on trailing edges.
  - After edge 2*DATA_W, sck is back at cpol.
- HOLD (H cycles): ss_n still asserted, sck idle, mosi holds last bit.
- Completion:
  - On the last HOLD cycle: ss_n all ones, busy=0, done=1 for exactly one cycle, rx_data updated in the same cycle.
  - Received bits are assembled MSB-first, or LSB-first when lsb_first=1.
  - Return to IDLE.
- Latency: busy high for exactly (2*DATA_W+2)*H cycles.
- start while busy=1: ignored, no latching.
- start in the cycle done=1: busy is already 0, so it is accepted.
- Input changes on cpol/cpha/tx_data etc. during a transfer have no effect.
- rst mid-transfer: abort, all outputs go to reset values, rx_data is cleared, no done pulse.
- clk_div=0 gives H=1, so SCK = clk/2.
- Bit counter width is clog2(2*DATA_W)+1. Divider counter is DIV_W bits and compares against the latched clk_div.

Test Plan:
- DATA_W=8, mode 0, clk_div=0, tx=0xA5, miso looped to mosi -> sck idle 0, 8 rising edges; rx_data=0xA5; busy high 18 cycles; done one 1-cycle pulse.
- Mode 3 (cpol=1,cpha=1), clk_div=3, tx=0x3C, miso tied 1 -> sck idle 1; busy 72 cycles; each sck level lasts 4 cycles; rx_data=0xFF.
- lsb_first=1, mode 1, tx=0x01, loopback -> mosi=1 during bit 0, 0 for the remaining 7 bits; rx_data=0x01.
- NUM_SS=4, ss_sel=2 -> ss_n=4'b1011 from SETUP through HOLD, then 4'b1111; ss_sel=5 -> ss_n stays 4'b1111 while the transfer still runs.
- start pulsed mid-transfer with tx=0x00, then rst asserted at cycle 10 of a 0xA5 transfer -> the second start is ignored (rx of the first transfer unaffected until reset); on rst: ss_n=1, sck=0, busy=0, rx_data=0, no done.
- DATA_W=16, back-to-back: start asserted in the done cycle, tx 0x1234 then 0xBEEF, loopback -> rx_data 0x1234 then 0xBEEF; ss_n high for exactly the done cycle between the words.
